// File: rtl/ac97_cmd_arbiter_if.sv
// rtl/ac97_cmd_arbiter_if.sv - command channel bundle for the AC97 register command arbiter
//
// Purpose: groups the frame timing, received status slots, requester handshake,
// response and outgoing command slot signals of ac97_cmd_arbiter.
// Ports (all carried as interface signals):
//   frame_start            one-cycle pulse on the SYNC rising edge
//   in_valid               one-cycle pulse, in_tag/in_slt1/in_slt2 hold a received frame
//   codec_ready            codec ready flag (input slot 0 bit 15, latched)
//   in_tag[15:0]           received slot 0
//   in_slt1, in_slt2       received status address / status data (20 bits each)
//   req_valid/req_rw       per-requester pending flag and direction (1 = read)
//   req_addr               7 bits per requester, requester i at [7i+6:7i]
//   req_wdata              16 bits per requester, requester i at [16i+15:16i]
//   req_ready              per-requester one-cycle accept pulse
//   rsp_valid/rsp_id       completion pulse and index of the completing requester
//   rsp_data/rsp_timeout   read data (0 for writes) and "read not answered" flag
//   out_tag[2:0]           {frame valid, slot1 valid, slot2 valid} for output slot 0
//   out_slt1, out_slt2     command address / command data (20 bits each)
//   busy                   arbiter is not idle
// Modports: slave = arbiter side, master = requester/serializer side.

interface ac97_cmd_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic                    frame_start;
  logic                    in_valid;
  logic                    codec_ready;
  logic [15:0]             in_tag;
  logic [19:0]             in_slt1;
  logic [19:0]             in_slt2;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_rw;
  logic [7*NUM_REQ-1:0]    req_addr;
  logic [16*NUM_REQ-1:0]   req_wdata;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    rsp_valid;
  logic [1:0]              rsp_id;
  logic [15:0]             rsp_data;
  logic                    rsp_timeout;
  logic [2:0]              out_tag;
  logic [19:0]             out_slt1;
  logic [19:0]             out_slt2;
  logic                    busy;

  modport slave (
    input  frame_start, in_valid, codec_ready, in_tag, in_slt1, in_slt2,
    input  req_valid, req_rw, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_timeout,
    output out_tag, out_slt1, out_slt2, busy
  );

  modport master (
    output frame_start, in_valid, codec_ready, in_tag, in_slt1, in_slt2,
    output req_valid, req_rw, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_timeout,
    input  out_tag, out_slt1, out_slt2, busy
  );
endinterface

// File: rtl/ac97_cmd_arbiter.sv
// rtl/ac97_cmd_arbiter.sv - frame-synchronous arbiter for the AC97 codec register command slots
//
// Purpose: grants at most one register read or write per AC97 frame to one of
// NUM_REQ requesters, drives the command slot words / slot-0 tag bits for the
// serializer and returns write completions, read data or read timeouts.
// Parameters: NUM_REQ (2..4) requesters, READ_TIMEOUT (1..15) frames to wait for read data.
// Ports:
//   BIT_CLOCK_I    codec bit clock, rising edge
//   AC97_RESETN_I  asynchronous active-low reset
//   bus            ac97_cmd_arbiter_if.slave (requests, responses, slot words, status input)
// Build option: define AC97_CMD_RR_EN for round-robin arbitration; otherwise
// fixed priority with the lowest requester index winning.

module ac97_cmd_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int READ_TIMEOUT = 4
) (
  input logic               BIT_CLOCK_I,
  input logic               AC97_RESETN_I,
  ac97_cmd_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT} state_t;

  localparam logic [3:0] TIMEOUT_CNT = 4'(READ_TIMEOUT);

  state_t             state_q, state_d;
  logic [1:0]         id_q, id_d;
  logic [6:0]         addr_q, addr_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [1:0]         rsp_id_q, rsp_id_d;
  logic [15:0]        rsp_data_q, rsp_data_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  logic [2:0]         out_tag_q, out_tag_d;
  logic [19:0]        out_slt1_q, out_slt1_d;
  logic [19:0]        out_slt2_q, out_slt2_d;
`ifdef AC97_CMD_RR_EN
  logic [1:0]         ptr_q, ptr_d;
`endif

  logic               grant_found;
  logic [1:0]         grant_id;
  logic               grant_rw;
  logic [6:0]         grant_addr;
  logic [15:0]        grant_wdata;
  logic               arb_ok;
  logic               read_match;
  logic [3:0]         cnt_inc;
  logic               unused_in_bits;

  // Only the status-address-valid tag bit, the echoed register index and the
  // 16 data bits of slot 2 take part in read completion.
  assign unused_in_bits = ^{bus.in_tag[15], bus.in_tag[13:0], bus.in_slt1[19],
                            bus.in_slt1[11:0], bus.in_slt2[3:0]};

  assign read_match = bus.in_valid && bus.in_tag[14] && (bus.in_slt1[18:12] == addr_q);
  assign cnt_inc    = cnt_q + 4'd1;

  // Grant selection over the live request vector.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    grant_rw    = 1'b0;
    grant_addr  = '0;
    grant_wdata = '0;
`ifdef AC97_CMD_RR_EN
    // Step k visits index (ptr + k) mod NUM_REQ, so the search starts at the
    // pointer and wraps; the inner loop keeps all slicing constant.
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_found && bus.req_valid[i] && (i == (int'(ptr_q) + k) % NUM_REQ)) begin
          grant_found = 1'b1;
          grant_id    = 2'(i);
          grant_rw    = bus.req_rw[i];
          grant_addr  = bus.req_addr[7*i +: 7];
          grant_wdata = bus.req_wdata[16*i +: 16];
        end
      end
    end
`else
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && bus.req_valid[i]) begin
        grant_found = 1'b1;
        grant_id    = 2'(i);
        grant_rw    = bus.req_rw[i];
        grant_addr  = bus.req_addr[7*i +: 7];
        grant_wdata = bus.req_wdata[16*i +: 16];
      end
    end
`endif
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    req_ready_d   = '0;
    rsp_valid_d   = 1'b0;
    rsp_id_d      = rsp_id_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    out_tag_d     = out_tag_q;
    out_slt1_d    = out_slt1_q;
    out_slt2_d    = out_slt2_q;
    arb_ok        = 1'b0;
`ifdef AC97_CMD_RR_EN
    ptr_d         = ptr_q;
`endif

    case (state_q)
      IDLE: arb_ok = bus.frame_start;

      WRITE: begin
        // The frame carrying the write has ended; completing and arbitrating
        // in the same cycle keeps back-to-back writes one per frame.
        if (bus.frame_start) begin
          rsp_valid_d   = 1'b1;
          rsp_id_d      = id_q;
          rsp_data_d    = 16'h0000;
          rsp_timeout_d = 1'b0;
          state_d       = IDLE;
          arb_ok        = 1'b1;
        end
      end

      READ_WAIT: begin
        if (bus.frame_start) begin
          out_tag_d  = 3'b100;
          out_slt1_d = '0;
          out_slt2_d = '0;
          cnt_d      = cnt_inc;
        end
        // A match takes precedence over a timeout landing in the same cycle.
        if (read_match) begin
          rsp_valid_d   = 1'b1;
          rsp_id_d      = id_q;
          rsp_data_d    = bus.in_slt2[19:4];
          rsp_timeout_d = 1'b0;
          state_d       = IDLE;
        end else if (bus.frame_start && ((cnt_inc >= TIMEOUT_CNT) || !bus.codec_ready)) begin
          rsp_valid_d   = 1'b1;
          rsp_id_d      = id_q;
          rsp_data_d    = 16'hFFFF;
          rsp_timeout_d = 1'b1;
          state_d       = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (arb_ok) begin
      out_tag_d  = 3'b100;
      out_slt1_d = '0;
      out_slt2_d = '0;
      if (bus.codec_ready && grant_found) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          req_ready_d[i] = (2'(i) == grant_id);
        end
        id_d   = grant_id;
        addr_d = grant_addr;
`ifdef AC97_CMD_RR_EN
        ptr_d  = 2'((int'(grant_id) + 1) % NUM_REQ);
`endif
        if (grant_rw) begin
          out_tag_d  = 3'b110;
          out_slt1_d = {1'b1, grant_addr, 12'h000};
          out_slt2_d = '0;
          cnt_d      = 4'd0;
          state_d    = READ_WAIT;
        end else begin
          out_tag_d  = 3'b111;
          out_slt1_d = {1'b0, grant_addr, 12'h000};
          out_slt2_d = {grant_wdata, 4'h0};
          state_d    = WRITE;
        end
      end
    end
  end

  always_ff @(posedge BIT_CLOCK_I or negedge AC97_RESETN_I) begin
    if (!AC97_RESETN_I) begin
      state_q       <= IDLE;
      id_q          <= '0;
      addr_q        <= '0;
      cnt_q         <= '0;
      req_ready_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      out_tag_q     <= '0;
      out_slt1_q    <= '0;
      out_slt2_q    <= '0;
`ifdef AC97_CMD_RR_EN
      ptr_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      id_q          <= id_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      out_tag_q     <= out_tag_d;
      out_slt1_q    <= out_slt1_d;
      out_slt2_q    <= out_slt2_d;
`ifdef AC97_CMD_RR_EN
      ptr_q         <= ptr_d;
`endif
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.out_tag     = out_tag_q;
  assign bus.out_slt1    = out_slt1_q;
  assign bus.out_slt2    = out_slt2_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ac97_cmd_arbiter.sv
// tb/tb_ac97_cmd_arbiter.sv - self-checking bench for ac97_cmd_arbiter (response scoreboard)

module tb_ac97_cmd_arbiter;

  localparam int FRAME_LEN = 16;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] data;
    logic        timeout;
  } rsp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   tb_ptr = 0;
  rsp_t sb[$];

  ac97_cmd_arbiter_if #(.NUM_REQ(2)) bus ();

  ac97_cmd_arbiter #(.NUM_REQ(2), .READ_TIMEOUT(4)) dut (
    .BIT_CLOCK_I   (clk),
    .AC97_RESETN_I (resetn),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  // Scoreboard: every response pulse is checked against the oldest expectation.
  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      rsp_t got, exp;
      got = {bus.rsp_id, bus.rsp_data, bus.rsp_timeout};
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: got id=%0d data=%h timeout=%b, required no response",
                 got.id, got.data, got.timeout);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL rsp_compare: got id=%0d data=%h timeout=%b, required id=%0d data=%h timeout=%b",
                   got.id, got.data, got.timeout, exp.id, exp.data, exp.timeout);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic frame_pulse();
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic status_frame(input logic [15:0] tag, input logic [19:0] s1, input logic [19:0] s2);
    bus.in_tag = tag; bus.in_slt1 = s1; bus.in_slt2 = s2; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [65:0] all_out;
    resetn = 1'b0;
    idle_cycles(3);
    all_out = {bus.out_tag, bus.out_slt1, bus.out_slt2, bus.req_ready, bus.rsp_valid,
               bus.rsp_id, bus.rsp_data, bus.rsp_timeout, bus.busy};
    n_checks++;
    if (all_out !== 66'h0) begin n_fail++; $display("FAIL reset_outputs: got %h, required 0", all_out); end
    resetn = 1'b1;
    idle_cycles(2);
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
  endtask

  task automatic test_write();
    bus.codec_ready = 1'b1;
    bus.req_valid = 2'b01; bus.req_rw = 2'b00;
    bus.req_addr = {7'h00, 7'h02}; bus.req_wdata = {16'h0000, 16'h0808};
    sb.push_back({2'd0, 16'h0000, 1'b0});
    @(negedge clk);
    frame_pulse();
    n_checks++;
    if ({bus.req_ready, bus.out_tag, bus.out_slt1, bus.out_slt2, bus.busy} !== {2'b01, 3'b111, 20'h02000, 20'h08080, 1'b1}) begin
      n_fail++;
      $display("FAIL write_grant: got ready=%b tag=%b slt1=%h slt2=%h busy=%b, required ready=01 tag=111 slt1=02000 slt2=08080 busy=1",
               bus.req_ready, bus.out_tag, bus.out_slt1, bus.out_slt2, bus.busy);
    end
    bus.req_valid = 2'b00;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL write_ready_pulse: got %b, required 00", bus.req_ready); end
    idle_cycles(FRAME_LEN - 2);
    n_checks++;
    if (bus.out_tag !== 3'b111) begin n_fail++; $display("FAIL write_tag_stable: got %b, required 111", bus.out_tag); end
    frame_pulse();
    n_checks++;
    if ({bus.rsp_valid, bus.out_tag, bus.busy} !== {1'b1, 3'b100, 1'b0}) begin
      n_fail++;
      $display("FAIL write_complete: got valid=%b tag=%b busy=%b, required valid=1 tag=100 busy=0", bus.rsp_valid, bus.out_tag, bus.busy);
    end
    tb_ptr = 1;
    #1;
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL write_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_read();
    bus.req_valid = 2'b10; bus.req_rw = 2'b10;
    bus.req_addr = {7'h26, 7'h00};
    sb.push_back({2'd1, 16'h000F, 1'b0});
    @(negedge clk);
    frame_pulse();
    n_checks++;
    if ({bus.req_ready, bus.out_tag, bus.out_slt1, bus.out_slt2} !== {2'b10, 3'b110, 20'hA6000, 20'h00000}) begin
      n_fail++;
      $display("FAIL read_grant: got ready=%b tag=%b slt1=%h slt2=%h, required ready=10 tag=110 slt1=a6000 slt2=00000",
               bus.req_ready, bus.out_tag, bus.out_slt1, bus.out_slt2);
    end
    tb_ptr = 0;
    bus.req_valid = 2'b00;
    idle_cycles(FRAME_LEN - 1);
    frame_pulse();
    n_checks++;
    if ({bus.out_tag, bus.out_slt1, bus.busy} !== {3'b100, 20'h00000, 1'b1}) begin
      n_fail++;
      $display("FAIL read_slot_revert: got tag=%b slt1=%h busy=%b, required tag=100 slt1=00000 busy=1", bus.out_tag, bus.out_slt1, bus.busy);
    end
    idle_cycles(3);
    status_frame(16'h6000, 20'h26000, 20'h000F0);
    n_checks++;
    if ({bus.rsp_valid, bus.busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL read_complete: got valid=%b busy=%b, required valid=1 busy=0", bus.rsp_valid, bus.busy);
    end
    idle_cycles(3);
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b0, 2'd1, 16'h000F}) begin
      n_fail++;
      $display("FAIL read_hold: got valid=%b id=%0d data=%h, required valid=0 id=1 data=000f", bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL read_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_timeout();
    bus.req_valid = 2'b01; bus.req_rw = 2'b01;
    bus.req_addr = {7'h00, 7'h1C};
    sb.push_back({2'd0, 16'hFFFF, 1'b1});
    frame_pulse();
    tb_ptr = 1;
    bus.req_valid = 2'b00;
    for (int f = 1; f <= 4; f++) begin
      idle_cycles(4);
      if (f == 2) status_frame(16'h6000, 20'h26000, 20'h12340);   // wrong register index
      else if (f == 3) status_frame(16'h2000, 20'h1C000, 20'h12340); // slot 1 tag bit clear
      else @(negedge clk);
      idle_cycles(FRAME_LEN - 6);
      frame_pulse();
      n_checks++;
      if ({bus.rsp_valid, bus.busy} !== ((f == 4) ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL timeout_frame%0d: got valid=%b busy=%b, required valid=%b busy=%b",
                 f, bus.rsp_valid, bus.busy, (f == 4), (f != 4));
      end
    end
    #1;
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL timeout_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_ready_drop();
    bus.req_valid = 2'b10; bus.req_rw = 2'b10;
    bus.req_addr = {7'h0A, 7'h00};
    sb.push_back({2'd1, 16'hFFFF, 1'b1});
    @(negedge clk);
    frame_pulse();
    tb_ptr = 0;
    bus.req_valid = 2'b00;
    idle_cycles(FRAME_LEN - 2);
    bus.codec_ready = 1'b0;
    @(negedge clk);
    frame_pulse();
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_timeout, bus.busy, bus.out_tag} !== {1'b1, 1'b1, 1'b0, 3'b100}) begin
      n_fail++;
      $display("FAIL ready_drop: got valid=%b timeout=%b busy=%b tag=%b, required valid=1 timeout=1 busy=0 tag=100",
               bus.rsp_valid, bus.rsp_timeout, bus.busy, bus.out_tag);
    end
    bus.codec_ready = 1'b1;
    #1;
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL ready_drop_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    int         exp;
    logic [1:0] exp_ready;
    logic [6:0] exp_addr;
    logic [15:0] exp_wdata;
    @(negedge clk);
    bus.req_valid = 2'b11; bus.req_rw = 2'b00;
    bus.req_addr = {7'h12, 7'h10}; bus.req_wdata = {16'h2222, 16'h1111};
    for (int g = 0; g < 4; g++) begin
`ifdef AC97_CMD_RR_EN
      exp = tb_ptr;
`else
      exp = 0;
`endif
      exp_ready = (exp == 0) ? 2'b01 : 2'b10;
      exp_addr  = (exp == 0) ? 7'h10 : 7'h12;
      exp_wdata = (exp == 0) ? 16'h1111 : 16'h2222;
      sb.push_back({2'(exp), 16'h0000, 1'b0});
      frame_pulse();
      n_checks++;
      if ({bus.req_ready, bus.out_tag, bus.out_slt1, bus.out_slt2} !== {exp_ready, 3'b111, 1'b0, exp_addr, 12'h000, exp_wdata, 4'h0}) begin
        n_fail++;
        $display("FAIL b2b_grant%0d: got ready=%b tag=%b slt1=%h slt2=%h, required ready=%b tag=111 slt1=%h slt2=%h",
                 g, bus.req_ready, bus.out_tag, bus.out_slt1, bus.out_slt2, exp_ready, {1'b0, exp_addr, 12'h000}, {exp_wdata, 4'h0});
      end
      tb_ptr = (exp + 1) % 2;
      idle_cycles(FRAME_LEN - 1);
    end
    bus.req_valid = 2'b00;
    frame_pulse();
    #1;
    n_checks++;
    if ({bus.busy, 32'(sb.size())} !== 33'h0) begin
      n_fail++;
      $display("FAIL b2b_drain: got busy=%b pending=%0d, required busy=0 pending=0", bus.busy, sb.size());
    end
  endtask

  task automatic test_codec_not_ready();
    @(negedge clk);
    bus.codec_ready = 1'b0;
    bus.req_valid = 2'b01; bus.req_rw = 2'b00;
    bus.req_addr = {7'h00, 7'h05}; bus.req_wdata = {16'h0000, 16'hABCD};
    for (int f = 0; f < 2; f++) begin
      frame_pulse();
      n_checks++;
      if ({bus.req_ready, bus.out_tag, bus.busy} !== {2'b00, 3'b100, 1'b0}) begin
        n_fail++;
        $display("FAIL not_ready_frame%0d: got ready=%b tag=%b busy=%b, required ready=00 tag=100 busy=0",
                 f, bus.req_ready, bus.out_tag, bus.busy);
      end
      idle_cycles(FRAME_LEN - 1);
    end
    bus.codec_ready = 1'b1;
    sb.push_back({2'd0, 16'h0000, 1'b0});
    frame_pulse();
    n_checks++;
    if ({bus.req_ready, bus.out_tag, bus.out_slt2} !== {2'b01, 3'b111, 20'hABCD0}) begin
      n_fail++;
      $display("FAIL not_ready_grant: got ready=%b tag=%b slt2=%h, required ready=01 tag=111 slt2=abcd0",
               bus.req_ready, bus.out_tag, bus.out_slt2);
    end
    tb_ptr = 1;
    bus.req_valid = 2'b00;
    idle_cycles(FRAME_LEN - 1);
    frame_pulse();
    #1;
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL not_ready_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_reset_mid_read();
    logic [65:0] all_out;
    @(negedge clk);
    bus.req_valid = 2'b01; bus.req_rw = 2'b01;
    bus.req_addr = {7'h00, 7'h33};
    frame_pulse();
    bus.req_valid = 2'b00;
    idle_cycles(FRAME_LEN - 1);
    frame_pulse();
    idle_cycles(2);
    resetn = 1'b0;
    #1;
    all_out = {bus.out_tag, bus.out_slt1, bus.out_slt2, bus.req_ready, bus.rsp_valid,
               bus.rsp_id, bus.rsp_data, bus.rsp_timeout, bus.busy};
    n_checks++;
    if (all_out !== 66'h0) begin n_fail++; $display("FAIL reset_mid_read: got %h, required 0", all_out); end
    tb_ptr = 0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    status_frame(16'h6000, 20'h33000, 20'h12340);
    n_checks++;
    if ({bus.rsp_valid, bus.busy, bus.rsp_data} !== {1'b0, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_no_rsp: got valid=%b busy=%b data=%h, required valid=0 busy=0 data=0000",
               bus.rsp_valid, bus.busy, bus.rsp_data);
    end
    idle_cycles(4);
  endtask

  initial begin
    bus.frame_start = 1'b0; bus.in_valid = 1'b0; bus.codec_ready = 1'b0;
    bus.in_tag = '0; bus.in_slt1 = '0; bus.in_slt2 = '0;
    bus.req_valid = '0; bus.req_rw = '0; bus.req_addr = '0; bus.req_wdata = '0;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_ready_drop();
    test_back_to_back();
    test_codec_not_ready();
    test_reset_mid_read();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL final_drain: got %0d pending, required 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ac97_cmd_arbiter.md
# ac97_cmd_arbiter

Frame-synchronous arbiter that shares the AC97 codec register command channel (output slots 1/2 and input slots 1/2) between several requesters, such as the init sequencer, runtime volume control and status polling. It accepts at most one register read or write per AC97 frame and drives the command slot words and slot-0 tag bits for the serializer. It returns read data and write completions to the issuing requester. It sits between the requesters and the slot serializer/deserializer, clocked by the codec bit clock.

## Interface
- NUM_REQ, 2, number of requesters (2..4)
- READ_TIMEOUT, 4, frames to wait for read data before a timeout response (1..15)
- BIT_CLOCK_I  in  1  codec bit clock; all logic on rising edge
- AC97_RESETN_I  in  1  reset, asynchronous, active-low
- FRAME_START_I  in  1  one-cycle pulse on the SYNC rising edge (frame boundary)
- IN_VALID_I  in  1  one-cycle pulse when IN_TAG_I/IN_SLT1_I/IN_SLT2_I hold a freshly received frame
- CODEC_READY_I  in  1  codec ready (input slot 0 bit 15, latched)
- IN_TAG_I  in  16  received slot 0
- IN_SLT1_I, IN_SLT2_I  in  20 each  received status address / status data
- REQ_VALID_I  in  NUM_REQ  request pending, one bit per requester
- REQ_RW_I  in  NUM_REQ  1 = read, 0 = write
- REQ_ADDR_I  in  7*NUM_REQ  register index, requester i at [7i+6:7i]
- REQ_WDATA_I  in  16*NUM_REQ  write data, requester i at [16i+15:16i]
- REQ_READY_O  out  NUM_REQ  one-cycle accept pulse
- RSP_VALID_O  out  1  one-cycle completion pulse
- RSP_ID_O  out  2  index of the completing requester
- RSP_DATA_O  out  16  read data (0 for writes)
- RSP_TIMEOUT_O  out  1  qualifies RSP_VALID_O: read not answered
- OUT_TAG_O  out  3  {frame valid, slot1 valid, slot2 valid} for output slot 0 bits 15:13
- OUT_SLT1_O, OUT_SLT2_O  out  20 each  command address / command data
- BUSY_O  out  1  state is not IDLE

## Operation
- Reset: state IDLE, all outputs 0, round-robin pointer 0.
- States: IDLE, WRITE, READ_WAIT.
- Arbitration happens only on FRAME_START_I in IDLE with CODEC_READY_I=1 and any REQ_VALID_I set. Grant goes to the first valid index at or after the pointer, wrapping. The pointer then becomes grant+1 mod NUM_REQ.
- Requesters hold VALID/RW/ADDR/WDATA stable until REQ_READY_O. Requests are sampled only at the arbitration cycle.
- Write grant:
  - OUT_SLT1_O = {1'b0, addr, 12'h000}, OUT_SLT2_O = {wdata, 4'h0}, OUT_TAG_O = 3'b111; go to WRITE.
  - At the next FRAME_START_I: RSP_VALID_O with RSP_DATA_O=0, then return to IDLE. Arbitration in that same cycle is allowed, giving back-to-back frames.
- Read grant:
  - OUT_SLT1_O = {1'b1, addr, 12'h000}, OUT_SLT2_O = 0, OUT_TAG_O = 3'b110.
  - Go to READ_WAIT with frame counter 0.
  - At the next FRAME_START_I, the slot words revert to idle.
- Idle slot values: OUT_TAG_O = 3'b100, OUT_SLT1_O = OUT_SLT2_O = 0.
- READ_WAIT:
  - A match is IN_VALID_I with IN_TAG_I[14]=1 and IN_SLT1_I[18:12]==addr.
  - On a match: RSP_DATA_O = IN_SLT2_I[19:4], RSP_TIMEOUT_O=0, RSP_VALID_O, then IDLE.
  - Each FRAME_START_I increments the counter. When the counter reaches READ_TIMEOUT, or CODEC_READY_I=0 at a FRAME_START_I, the block responds with RSP_DATA_O=16'hFFFF, RSP_TIMEOUT_O=1, then IDLE.
- A match and a timeout in the same cycle: the match wins.
- RSP_ID_O and RSP_DATA_O hold their value until the next response.

## Timing
- REQ_READY_O and the OUT_* update are registered: they occur in the cycle after the FRAME_START_I that granted. OUT_* stay stable for the whole frame (at least 250 bit clocks).
- The serializer samples OUT_* at its load point, at least 2 cycles after FRAME_START_I.
- Write RSP_VALID_O: the cycle after the FRAME_START_I that ends the write frame, one frame after grant.
- Read RSP_VALID_O: the cycle after the matching IN_VALID_I. A read normally completes 1–2 frames after grant.
- Asserting AC97_RESETN_I mid-transaction aborts immediately, with no response. Requesters must reissue.

## Configuration
- AC97_CMD_RR_EN defined: round-robin arbitration as above.
- Not defined: fixed priority, lowest index wins, and the pointer is unused. This lets the init sequencer on index 0 always win.

## Test plan
- Write req0 addr 7'h02 data 16'h0808 -> REQ_READY_O[0] after the next FRAME_START. That frame carries OUT_TAG 3'b111, SLT1 20'h02000, SLT2 20'h08080. RSP_VALID id 0 one frame later.
- Read req1 addr 7'h26; codec answers next frame with slot1 {0,7'h26,12'h0}, slot2 20'h000F0 -> RSP_VALID id 1, RSP_DATA 16'h000F, TIMEOUT 0.
- Read with no codec answer, READ_TIMEOUT=4 -> response after the 4th FRAME_START with RSP_DATA 16'hFFFF, TIMEOUT 1.
- req0 and req1 both valid continuously -> with AC97_CMD_RR_EN, grants alternate 0,1,0,1. Without it, all grants go to 0.
- CODEC_READY_I=0 with a pending request -> no grant and OUT_TAG 3'b100. Granting starts at the first frame after ready rises.
- Reset pulse during READ_WAIT -> all outputs 0, no RSP_VALID, BUSY_O 0.
